// File: rtl/mem_port_arbiter.sv
`timescale 1ns / 1ps
// mem_port_arbiter: two-port round-robin arbiter in front of a single memory port.
// Latches the winning request, holds the memory request until ack, then pulses
// done for the owner together with the captured read data.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  sel,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  last_owner_q, last_owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            last_owner_q <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    // Arbitration, request latching and completion handling.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie the port that did not own the memory last wins.
                if (m0_req && (!m1_req || last_owner_q)) begin
                    m0_gnt = 1'b1;
                end else if (m1_req) begin
                    m1_gnt = 1'b1;
                end

                if (m0_gnt) begin
                    addr_d       = m0_addr;
                    we_d         = m0_we;
                    wdata_d      = m0_wdata;
                    sel_d        = 1'b0;
                    last_owner_d = 1'b0;
                    state_d      = StBusy;
                end else if (m1_gnt) begin
                    addr_d       = m1_addr;
                    we_d         = m1_we;
                    wdata_d      = m1_wdata;
                    sel_d        = 1'b1;
                    last_owner_d = 1'b1;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side and status outputs come straight from registers.
    always_comb begin
        mem_req   = (state_q == StBusy);
        busy      = (state_q == StBusy);
        mem_addr  = addr_q;
        mem_we    = we_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
        sel       = sel_q;
        m0_done   = done0_q;
        m1_done   = done1_q;
    end

endmodule
